// File: rtl/fds_reg_sequencer.sv
// FDS register restore sequencer: replays a 107-write snapshot through the CPU register port.
// Optional conflict counter enabled by FDS_SEQ_CONFLICT_CNT_EN.
module fds_reg_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        m2,
  input  logic        cpu_wr,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_din,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [6:0]  snap_addr,
  input  logic [7:0]  snap_data,
  output logic        out_wr,
  output logic [15:0] out_addr,
  output logic [7:0]  out_data,
  output logic [7:0]  conflict_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    WAVE_OPEN,
    WAVE,
    WAVE_CLOSE,
    MOD_HALT,
    MOD,
    REGS,
    FINISH
  } state_t;

  localparam logic [6:0] LAST_STEP = 7'd106;

  state_t      state, state_n;
  logic [6:0]  step, step_n;
  logic        seq_wr, seq_wr_n;
  logic [15:0] seq_addr, seq_addr_n;
  logic [7:0]  seq_data, seq_data_n;
  logic [6:0]  snap_addr_n;
  logic        m2_q;
  logic        m2_rise;
  logic        consume;
  logic [6:0]  nstep;

  assign m2_rise = m2 & ~m2_q;
  assign consume = m2_rise & seq_wr & ~cpu_wr;
  assign nstep   = step + 7'd1;

  assign busy = (state != IDLE);
  assign done = (state == FINISH);

  assign out_wr   = cpu_wr | seq_wr;
  assign out_addr = cpu_wr ? cpu_addr : seq_addr;
  assign out_data = cpu_wr ? cpu_din  : seq_data;

  function automatic logic [15:0] reg_addr(input logic [6:0] s);
    logic [15:0] a;
    a = 16'h408A;
    unique case (s)
      7'd99:   a = 16'h4080;
      7'd100:  a = 16'h4082;
      7'd101:  a = 16'h4083;
      7'd102:  a = 16'h4084;
      7'd103:  a = 16'h4085;
      7'd104:  a = 16'h4086;
      7'd105:  a = 16'h4087;
      default: a = 16'h408A;
    endcase
    return a;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      step      <= '0;
      seq_wr    <= 1'b0;
      seq_addr  <= '0;
      seq_data  <= '0;
      snap_addr <= '0;
      m2_q      <= 1'b0;
    end else begin
      state     <= state_n;
      step      <= step_n;
      seq_wr    <= seq_wr_n;
      seq_addr  <= seq_addr_n;
      seq_data  <= seq_data_n;
      snap_addr <= snap_addr_n;
      m2_q      <= m2;
    end
  end

  always_comb begin
    state_n     = state;
    step_n      = step;
    seq_wr_n    = seq_wr;
    seq_addr_n  = seq_addr;
    seq_data_n  = seq_data;
    snap_addr_n = snap_addr;
    unique case (state)
      IDLE: begin
        seq_wr_n = 1'b0;
        if (start) begin
          state_n     = WAVE_OPEN;
          step_n      = '0;
          seq_wr_n    = 1'b1;
          seq_addr_n  = 16'h4089;
          seq_data_n  = 8'h80;
          snap_addr_n = '0;
        end
      end
      FINISH: begin
        state_n     = IDLE;
        step_n      = '0;
        seq_wr_n    = 1'b0;
        snap_addr_n = '0;
      end
      default: begin
        if (consume) begin
          if (step == LAST_STEP) begin
            state_n     = FINISH;
            seq_wr_n    = 1'b0;
            snap_addr_n = '0;
          end else begin
            step_n      = nstep;
            seq_data_n  = snap_data;
            // Prefetch the index of the next data-bearing step.
            snap_addr_n = (nstep <= 7'd65) ? nstep : nstep - 7'd1;
            unique case (1'b1)
              (nstep <= 7'd64): begin
                state_n    = WAVE;
                seq_addr_n = 16'h403F + {9'd0, nstep};
              end
              (nstep == 7'd65): begin
                state_n    = WAVE_CLOSE;
                seq_addr_n = 16'h4089;
                seq_data_n = snap_data & 8'h03;
              end
              (nstep == 7'd66): begin
                state_n    = MOD_HALT;
                seq_addr_n = 16'h4087;
                seq_data_n = 8'h80;
              end
              (nstep >= 7'd67 && nstep <= 7'd98): begin
                state_n    = MOD;
                seq_addr_n = 16'h4088;
              end
              default: begin
                state_n    = REGS;
                seq_addr_n = reg_addr(nstep);
              end
            endcase
          end
        end
      end
    endcase
  end

`ifdef FDS_SEQ_CONFLICT_CNT_EN
  logic [7:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (state == IDLE && start) begin
      cnt_q <= '0;
    end else if (m2_rise && seq_wr && cpu_wr && cnt_q != 8'hFF) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  assign conflict_cnt = cnt_q;
`else
  assign conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_fds_reg_sequencer.sv
// Directed bench for fds_reg_sequencer: idle mux vectors plus restore,
// conflict, restart, reset-abort and saturation sequences.
module tb_fds_reg_sequencer;

  logic        clk;
  logic        reset;
  logic        m2;
  logic        cpu_wr;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_din;
  logic        start;
  logic        busy;
  logic        done;
  logic [6:0]  snap_addr;
  logic [7:0]  snap_data;
  logic        out_wr;
  logic [15:0] out_addr;
  logic [7:0]  out_data;
  logic [7:0]  conflict_cnt;

  fds_reg_sequencer dut (
    .clk(clk),
    .reset(reset),
    .m2(m2),
    .cpu_wr(cpu_wr),
    .cpu_addr(cpu_addr),
    .cpu_din(cpu_din),
    .start(start),
    .busy(busy),
    .done(done),
    .snap_addr(snap_addr),
    .snap_data(snap_data),
    .out_wr(out_wr),
    .out_addr(out_addr),
    .out_data(out_data),
    .conflict_cnt(conflict_cnt)
  );

  logic [7:0]  snap_mem [0:127];
  logic [23:0] wlog [$];
  logic [23:0] exp_q [$];
  logic        m2_last;
  int          ph;
  int          done_cnt;
  int          checks;
  int          errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) snap_data <= snap_mem[snap_addr];

  // Record every write presented on an m2 rise.
  always @(posedge clk) begin
    if (!reset && m2 && !m2_last && out_wr)
      wlog.push_back({out_addr, out_data});
    if (done) done_cnt++;
    m2_last <= m2;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    ph = (ph + 1) % 6;
    m2 = (ph >= 3);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] exp_step(input int k);
    logic [15:0] a;
    if (k == 0) return {16'h4089, 8'h80};
    if (k <= 64) return {16'h4040 + 16'(k - 1), snap_mem[k - 1]};
    if (k == 65) return {16'h4089, snap_mem[64] & 8'h03};
    if (k == 66) return {16'h4087, 8'h80};
    if (k <= 98) return {16'h4088, snap_mem[k - 2]};
    case (k)
      99:      a = 16'h4080;
      100:     a = 16'h4082;
      101:     a = 16'h4083;
      102:     a = 16'h4084;
      103:     a = 16'h4085;
      104:     a = 16'h4086;
      105:     a = 16'h4087;
      default: a = 16'h408A;
    endcase
    return {a, snap_mem[k - 2]};
  endfunction

  task automatic build_exp(input int n);
    exp_q.delete();
    for (int k = 0; k < n; k++) exp_q.push_back(exp_step(k));
  endtask

  task automatic cmp_log(input string nm);
    int bad;
    int first;
    int n;
    bad = 0;
    first = -1;
    n = (wlog.size() < exp_q.size()) ? wlog.size() : exp_q.size();
    chk({nm, "_len"}, wlog.size(), exp_q.size());
    for (int i = 0; i < n; i++)
      if (wlog[i] !== exp_q[i]) begin
        bad++;
        if (first < 0) first = i;
      end
    if (first >= 0)
      $display("first diff %s at %0d: got %h want %h",
               nm, first, wlog[first], exp_q[first]);
    chk({nm, "_order"}, bad, 0);
  endtask

  function automatic logic [23:0] log_at(input int i);
    if (i < wlog.size()) return wlog[i];
    return 24'h0;
  endfunction

  task automatic run(input string nm, input int conf_at, input int rs_at,
                     input int rst_at, input int hold);
    bit conf_done;
    bit rs_done;
    bit rise_next;
    int rises;
    int cyc;
    conf_done = 0;
    rs_done = 0;
    rises = 0;
    wlog.delete();
    done_cnt = 0;
    cpu_wr = 0;
    while (ph != 2) tick();
    // Start lands on the same edge as an m2 rise.
    start = 1;
    tick();
    start = 0;
    if (hold == 0) begin
      chk({nm, "_busy_start"}, busy, 1);
      chk({nm, "_step0"}, {out_wr, out_addr, out_data}, {1'b1, 24'h408980});
    end
    for (cyc = 0; cyc < 4000; cyc++) begin
      if (done_cnt > 0 && !busy) break;
      rise_next = (ph == 2);
      cpu_wr = (rises < hold);
      cpu_addr = 16'h4085;
      cpu_din = 8'h00;
      start = 0;
      if (cpu_wr && rise_next) rises++;
      if (rise_next && wlog.size() == conf_at && !conf_done) begin
        cpu_wr = 1;
        cpu_din = 8'h12;
        conf_done = 1;
      end
      if (wlog.size() == rs_at && !rs_done) begin
        start = 1;
        rs_done = 1;
      end
      if (wlog.size() == rst_at) begin
        reset = 1;
        tick();
        reset = 0;
        cpu_wr = 0;
        return;
      end
      tick();
    end
    start = 0;
    cpu_wr = 0;
    chk({nm, "_finished"}, (cyc < 4000), 1);
  endtask

  typedef struct {
    logic        wr;
    logic [15:0] a;
    logic [7:0]  d;
    logic        ewr;
    logic [15:0] ea;
    logic [7:0]  ed;
  } vec_t;

  initial begin
    vec_t vecs [5];
    vecs[0] = '{1'b0, 16'h1234, 8'h56, 1'b0, 16'h0000, 8'h00};
    vecs[1] = '{1'b1, 16'h4085, 8'h12, 1'b1, 16'h4085, 8'h12};
    vecs[2] = '{1'b1, 16'hFFFF, 8'hFF, 1'b1, 16'hFFFF, 8'hFF};
    vecs[3] = '{1'b0, 16'h4089, 8'h80, 1'b0, 16'h0000, 8'h00};
    vecs[4] = '{1'b1, 16'h0000, 8'h00, 1'b1, 16'h0000, 8'h00};

    checks = 0;
    errors = 0;
    done_cnt = 0;
    ph = 0;
    m2 = 0;
    m2_last = 0;
    reset = 1;
    start = 0;
    cpu_wr = 0;
    cpu_addr = 0;
    cpu_din = 0;
    for (int k = 0; k < 128; k++) snap_mem[k] = 8'(k);

    repeat (3) tick();
    reset = 0;
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_out", {out_wr, out_addr, out_data}, 25'h0);
    chk("rst_snap_addr", snap_addr, 0);
    chk("rst_conflict", conflict_cnt, 0);

    for (int i = 0; i < 5; i++) begin
      cpu_wr = vecs[i].wr;
      cpu_addr = vecs[i].a;
      cpu_din = vecs[i].d;
      tick();
      chk($sformatf("mux_%0d", i), {out_wr, out_addr, out_data},
          {vecs[i].ewr, vecs[i].ea, vecs[i].ed});
    end
    cpu_wr = 0;
    tick();

    run("full", -1, -1, -1, 0);
    build_exp(107);
    cmp_log("full");
    chk("full_done", done_cnt, 1);
    chk("full_busy_end", busy, 0);
    chk("full_w1", log_at(1), 24'h404000);
    chk("full_w64", log_at(64), 24'h407F3F);
    chk("full_w65", log_at(65), 24'h408900);

    snap_mem[64] = 8'hFF;
    run("restart", -1, 40, -1, 0);
    build_exp(107);
    cmp_log("restart");
    chk("restart_done", done_cnt, 1);
    chk("restart_w65", log_at(65), 24'h408903);
    snap_mem[64] = 8'd64;

    run("conf", 10, -1, -1, 0);
    build_exp(107);
    exp_q.insert(10, 24'h408512);
    cmp_log("conf");
    chk("conf_done", done_cnt, 1);
`ifdef FDS_SEQ_CONFLICT_CNT_EN
    chk("conf_cnt", conflict_cnt, 1);
`else
    chk("conf_cnt", conflict_cnt, 0);
`endif

    run("abort", -1, -1, 70, 0);
    chk("abort_busy", busy, 0);
    chk("abort_out_wr", out_wr, 0);
    chk("abort_conflict", conflict_cnt, 0);
    repeat (30) tick();
    chk("abort_len", wlog.size(), 70);
    chk("abort_no_done", done_cnt, 0);
    cpu_wr = 1;
    cpu_addr = 16'h1234;
    cpu_din = 8'h56;
    tick();
    chk("abort_cpu", {out_wr, out_addr, out_data}, {1'b1, 24'h123456});
    cpu_wr = 0;
    tick();

    run("fresh", -1, -1, -1, 0);
    build_exp(107);
    cmp_log("fresh");
    chk("fresh_done", done_cnt, 1);

    run("hold", -1, -1, -1, 300);
    build_exp(107);
    for (int i = 0; i < 300; i++) exp_q.push_front(24'h408500);
    cmp_log("hold");
`ifdef FDS_SEQ_CONFLICT_CNT_EN
    chk("hold_cnt", conflict_cnt, 255);
`else
    chk("hold_cnt", conflict_cnt, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
